ucode_loader: RTL
=================

// Module: ucode_loader
// PURPOSE
//  Writer side of the controller's 49-bit microcode store. It receives a byte stream
//  through a valid/ready handshake and assembles 49-bit microinstructions from it.
//  It writes the instructions to control-store addresses 0..N-1 in order.
//  It holds the controller in reset during the load and releases it when the load completes.
//  It sits between the host/input byte buffer and the controller's program memory write port.
// PARAMETERS
//  INSTR_WIDTH     49  microinstruction width in bits
//  ADDR_WIDTH      8   control-store address width (256 words)
//  BYTES_PER_WORD  7   bytes per instruction, ceil(INSTR_WIDTH/8)
// PORTS
//  clk         in   1            single clock; all logic on posedge
//  reset       in   1            synchronous, active-low reset
//  start       in   1            1-cycle pulse that begins a load
//  in_data     in   8            stream byte
//  in_valid    in   1            in_data is valid
//  in_ready    out  1            loader accepts a byte this cycle
//  mem_we      out  1            control-store write strobe
//  mem_addr    out  ADDR_WIDTH   write address
//  mem_wdata   out  INSTR_WIDTH  write data
//  ctrl_reset  out  1            active-low reset to the controller; 0 holds it
//  busy        out  1            load in progress
//  done        out  1            load completed successfully (sticky)
//  error       out  1            malformed stream (sticky)
// BEHAVIOUR
//  - Reset (reset==0 at posedge) applies on the next cycle:
//    all outputs go to 0, state goes to IDLE, counters clear.
//    The controller is therefore held in reset until a load succeeds.
//  - A byte transfers at a posedge where in_valid && in_ready. No combinational path from in_valid to in_ready.
//  - Stream format:
//    - Byte 0 is N, the word count; N==0 means 256 words.
//    - N words follow, each BYTES_PER_WORD bytes, little-endian (first byte = bits[7:0]).
//    - The last byte of each word supplies bit 48 from its bit 0; its bits[7:1] must be 0.
//  - FSM states:
//    - IDLE: in_ready=0, busy=0. start -> COUNT. Entering COUNT clears done/error and drives ctrl_reset=0.
//    - COUNT: in_ready=1, busy=1. On a transfer, latch N and clear word_idx and byte_idx -> ASSEMBLE.
//    - ASSEMBLE: in_ready=1. Each transfer shifts the byte into the shift register and increments byte_idx.
//      On the transfer with byte_idx==6:
//      - If in_data[7:1]!=0 -> ERROR.
//      - Otherwise -> WRITE.
//    - WRITE (exactly 1 cycle): in_ready=0, mem_we=1, mem_addr=word_idx, mem_wdata=assembled word.
//      - If word_idx==N-1 (mod 256) -> DONE.
//      - Otherwise increment word_idx and clear byte_idx -> ASSEMBLE.
//    - DONE: done=1, ctrl_reset=1, busy=0, in_ready=0. start -> COUNT.
//    - ERROR: error=1, ctrl_reset=0, busy=0, in_ready=0. No write for the bad word. start -> COUNT.
//  - Latency: mem_we asserts the cycle after the 7th byte of a word transfers.
//    done and ctrl_reset=1 assert the cycle after the final WRITE.
//  - mem_addr/mem_wdata hold their last values outside WRITE. mem_we is never high outside WRITE.
//  - Counters: word_idx is an ADDR_WIDTH-bit counter and never exceeds 255.
//    byte_idx counts 0..6 and then wraps to 0.
//  - start while busy (COUNT/ASSEMBLE/WRITE) is ignored.
//  - start in the same cycle as reset==0: reset wins.
//  - Reset mid-load aborts the load. Words already written are not rolled back.
//    ctrl_reset stays 0 until a later load completes.
//  - in_valid gaps or stalls: no timeout; the loader waits indefinitely in the current state.
// TESTING
//  1. start; bytes 01,FF,FF,FF,FF,FF,FF,01
//     -> one mem_we, addr 0, data 49'h1_FFFF_FFFF_FFFF;
//     done=1 and ctrl_reset=1 on the next cycle.
//  2. N=00 then 256 words where word k = k
//     -> 256 mem_we pulses at addrs 0..255 in order, wdata==addr; done=1.
//  3. N=03 with in_valid low every other cycle and random stalls
//     -> same writes and data as the gap-free run; in_ready=0 during each WRITE cycle.
//  4. N=02; word 1 last byte=02
//     -> word 0 written; no write for word 1; error=1, ctrl_reset=0, in_ready=0.
//  5. N=05; reset low during word 3
//     -> all outputs 0 the next cycle.
//     A later start plus a good stream -> all 5 words written, done=1.
//  6. start pulsed during ASSEMBLE
//     -> ignored, word_idx/byte_idx unchanged.
//     start in DONE -> done clears, ctrl_reset=0, new load proceeds.

Source files
------------

// File: rtl/ucode_loader.sv
// rtl/ucode_loader.sv - byte-stream microcode loader for the controller's 49-bit control store
// Holds the controller in reset while a counted, little-endian word stream is written to addresses 0..N-1.
module ucode_loader #(
    parameter int INSTR_WIDTH    = 49,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INSTR_WIDTH-1:0] mem_wdata,
    output logic                   ctrl_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int SR_W      = 8 * (BYTES_PER_WORD - 1);
    localparam int LAST_BITS = INSTR_WIDTH - SR_W;
    localparam int BI_W      = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_ASSEMBLE,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] n_words;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [BI_W-1:0]       byte_idx;
    logic [SR_W-1:0]       sreg;

    wire xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            sreg       <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ctrl_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state      <= S_COUNT;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        ctrl_reset <= 1'b0;
                        busy       <= 1'b1;
                        in_ready   <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        n_words  <= ADDR_WIDTH'(in_data);
                        word_idx <= '0;
                        byte_idx <= '0;
                        state    <= S_ASSEMBLE;
                    end
                end
                S_ASSEMBLE: begin
                    if (xfer) begin
                        sreg <= {in_data, sreg[SR_W-1:8]};
                        if (byte_idx == BI_W'(BYTES_PER_WORD - 1)) begin
                            byte_idx <= '0;
                            in_ready <= 1'b0;
                            // Only the low LAST_BITS of the final byte carry instruction bits.
                            if ((in_data >> LAST_BITS) != 8'd0) begin
                                state <= S_ERROR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state     <= S_WRITE;
                                mem_we    <= 1'b1;
                                mem_addr  <= word_idx;
                                mem_wdata <= {in_data[LAST_BITS-1:0], sreg};
                            end
                        end else begin
                            byte_idx <= byte_idx + BI_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    mem_we <= 1'b0;
                    // n_words==0 encodes a full store, so N-1 wraps to the top address.
                    if (word_idx == n_words - ADDR_WIDTH'(1)) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        ctrl_reset <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        word_idx <= word_idx + ADDR_WIDTH'(1);
                        byte_idx <= '0;
                        in_ready <= 1'b1;
                        state    <= S_ASSEMBLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
